fc_1st_window_reader: RTL and testbench
=======================================

FC_1ST_WINDOW_READER -- requirements
Module: fc_1st_window_reader

Interface
REQ-001 Parameter Bit_width, default 16, data lane width.
REQ-002 Parameter RAM_Depth, default 32, entries in the FC first-layer data RAM.
REQ-003 CLK  input  1  sole clock; all state updates on posedge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  one-cycle pulse that begins a pass over the RAM.
REQ-006 Busy  output  1  high from Start acceptance until the last window is accepted.
REQ-007 Done  output  1  one-cycle pulse after the last window is accepted.
REQ-008 Read_Enable  output  1  RAM read strobe, sampled by the RAM on negedge CLK.
REQ-009 Read_Width  output  5  RAM window base address.
REQ-010 ram_data_0..ram_data_4  input  Bit_width each, signed  RAM window lanes, valid at the posedge after the read strobe.
REQ-011 win_data_0..win_data_4  output  Bit_width each, signed  registered window to the downstream MAC.
REQ-012 win_valid  output  1  window valid.
REQ-013 win_ready  input  1  downstream accepts the window when win_valid and win_ready are both high at a posedge.
REQ-014 win_index  output  3  index of the presented window, 0..6.
REQ-015 win_last  output  1  high with win_valid when win_index = NUM_WIN-1.

Function
REQ-016 Window base addresses SHALL be 5*k for k = 0..NUM_WIN-1; NUM_WIN = ceil(RAM_Depth/5) = 7. Last base is 30.
REQ-017 FSM states SHALL be IDLE, READ and VALID.
REQ-018 IDLE: Start SHALL advance to READ, clear the index to 0 and raise Busy at the next posedge. Start SHALL be ignored in every other state.
REQ-019 READ: Read_Enable SHALL be 1 and Read_Width SHALL equal 5*index for exactly one cycle. The FSM SHALL then go to VALID, capturing ram_data_0..4 into win_data_0..4 and setting win_valid.
REQ-020 VALID: win_valid and win_data SHALL hold stable until a handshake occurs. Read_Enable SHALL be 0 unless REQ-030 applies.
REQ-021 A handshake on a non-last window SHALL increment the index and move the FSM to READ. This does not apply when REQ-030 is in effect.
REQ-022 A handshake on the last window SHALL clear win_valid and Busy, return the FSM to IDLE and pulse Done for the following cycle.
REQ-023 Lanes beyond RAM_Depth-1 SHALL be passed through unmodified; the RAM zero-pads them.
REQ-024 Start-to-first-win_valid latency SHALL be 2 cycles.
REQ-025 Without prefetch, sustained throughput SHALL be one window per 2 cycles.
REQ-026 Start arriving in the same cycle as the Done pulse SHALL be accepted, because the FSM is already in IDLE.

Reset
REQ-027 While RST_N is low, all of the following SHALL be forced to 0, regardless of CLK: FSM state (IDLE), index, Busy, Done, Read_Enable, Read_Width, win_valid, win_data_0..4, win_index and win_last.
REQ-028 Reset asserted mid-pass SHALL abort the pass with no Done pulse.
REQ-029 Reset deassertion SHALL be treated as synchronous to CLK by the integrating design.

Configuration
REQ-030 Macro FC1_READER_PREFETCH_EN.
- Defined: during a non-last handshake in VALID, Read_Enable SHALL be driven combinationally to 1, with Read_Width = 5*(index+1).
- The FSM SHALL stay in VALID and capture the next window at the next posedge.
- Throughput SHALL be one window per cycle while win_ready is held high.
REQ-031 Undefined: Read_Enable SHALL be asserted only in READ and SHALL be a registered output.

Structure
REQ-032 Package fc1_reader_pkg SHALL hold Bit_width, RAM_Depth, WIN_LANES = 5, NUM_WIN = 7 and the FSM state enum.
REQ-033 Sub-module fc1_win_counter SHALL hold the index register and produce the base address (index*5, as shift-add), the next base address and the last flag.

Verification
REQ-034 RAM[i] = i+1. Start with win_ready = 1 -> 7 windows. Window 0 = {1,2,3,4,5}, window 6 = {31,32,0,0,0}, win_last only on window 6, Done once.
REQ-035 win_ready = 0 for 5 cycles on window 2 -> win_data = {11,12,13,14,15} held stable, Read_Enable stays 0, and no window is skipped.
REQ-036 Start pulsed again while Busy -> ignored, and the index sequence 0..6 is unaffected.
REQ-037 RST_N low during window 3 -> all outputs 0 immediately, no Done. The next Start restarts at window 0.
REQ-038 With FC1_READER_PREFETCH_EN and win_ready = 1 -> 7 windows in 7 consecutive cycles, starting 2 cycles after Start. Without the macro -> 14 cycles.
REQ-039 Signed data: RAM[0..4] = -1 (0xFFFF) -> window 0 lanes = -1, and the sign is preserved.

Source files
------------

// File: rtl/fc1_reader_pkg.sv
// fc1_reader_pkg: shared sizes, FSM encoding and address helper for the FC first-layer window reader
//   Bit_width  default data lane width
//   RAM_Depth  default number of entries in the FC first-layer data RAM
//   WIN_LANES  lanes per window (5)
//   NUM_WIN    windows per pass, ceil(RAM_Depth / WIN_LANES) = 7
//   state_t    IDLE / READ / VALID
package fc1_reader_pkg;
   localparam int Bit_width = 16;
   localparam int RAM_Depth = 32;
   localparam int WIN_LANES = 5;
   localparam int NUM_WIN   = (RAM_Depth + WIN_LANES - 1) / WIN_LANES;
   localparam int IDX_W     = 3;
   localparam int ADDR_W    = 5;
   typedef enum logic [1:0] {IDLE, READ, VALID} state_t;
   // index*5 as shift-add, avoids a multiplier
   function automatic logic [ADDR_W-1:0] times5(input logic [IDX_W-1:0] i);
      return ({2'b00, i} << 2) + {2'b00, i};
   endfunction
endpackage

// File: rtl/fc1_win_counter.sv
// fc1_win_counter: window index register with shift-add base address, next base and last-window flag
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         clear index to 0 (wins over inc)
//   inc         advance to the next window
//   index       current window index
//   base        5*index
//   next_base   5*(index+1)
//   last        index is the final window of the pass
module fc1_win_counter
   import fc1_reader_pkg::*;
#(
   parameter int LAST = NUM_WIN - 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              inc,
   output logic [IDX_W-1:0]  index,
   output logic [ADDR_W-1:0] base,
   output logic [ADDR_W-1:0] next_base,
   output logic              last
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) index <= '0;
      else if (clr) index <= '0;
      else if (inc) index <= index + 1'b1;
   assign base      = times5(index);
   assign next_base = base + ADDR_W'(WIN_LANES);
   assign last      = (index == IDX_W'(LAST));
endmodule

// File: rtl/fc_1st_window_reader.sv
// fc_1st_window_reader: walks the FC first-layer RAM in 5-lane windows and hands them to the MAC
//   CLK, RST_N           clock, asynchronous active-low reset
//   Start                one-cycle pulse that begins a pass (ignored unless idle)
//   Busy, Done           pass in progress / one-cycle pulse after the last window is accepted
//   Read_Enable          RAM read strobe (RAM samples on negedge CLK)
//   Read_Width           RAM window base address
//   ram_data_0..4        RAM window lanes, valid at the posedge after the strobe
//   win_data_0..4        registered window to the MAC
//   win_valid/win_ready  window handshake
//   win_index, win_last  index of the presented window / final window flag
// Optional macro FC1_READER_PREFETCH_EN: on a non-last handshake the next window is read
// combinationally in the same cycle, giving one window per cycle. Without it Read_Enable is
// registered and each window takes a READ cycle plus a VALID cycle.
module fc_1st_window_reader #(
   parameter int Bit_width = fc1_reader_pkg::Bit_width,
   parameter int RAM_Depth = fc1_reader_pkg::RAM_Depth
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic                        Start,
   output logic                        Busy,
   output logic                        Done,
   output logic                        Read_Enable,
   output logic [4:0]                  Read_Width,
   input  logic signed [Bit_width-1:0] ram_data_0,
   input  logic signed [Bit_width-1:0] ram_data_1,
   input  logic signed [Bit_width-1:0] ram_data_2,
   input  logic signed [Bit_width-1:0] ram_data_3,
   input  logic signed [Bit_width-1:0] ram_data_4,
   output logic signed [Bit_width-1:0] win_data_0,
   output logic signed [Bit_width-1:0] win_data_1,
   output logic signed [Bit_width-1:0] win_data_2,
   output logic signed [Bit_width-1:0] win_data_3,
   output logic signed [Bit_width-1:0] win_data_4,
   output logic                        win_valid,
   input  logic                        win_ready,
   output logic [2:0]                  win_index,
   output logic                        win_last
);
   import fc1_reader_pkg::*;
   localparam int LAST = (RAM_Depth + WIN_LANES - 1) / WIN_LANES - 1;
   state_t state, nxt;
   logic load, clr, inc, done_d, last;
   logic [IDX_W-1:0] index;
   logic [ADDR_W-1:0] base, next_base;
   // index is also cleared on the last handshake, so it is always 0 while idle
   fc1_win_counter #(.LAST(LAST)) u_cnt (
      .clk(CLK), .rst_n(RST_N), .clr(clr), .inc(inc),
      .index(index), .base(base), .next_base(next_base), .last(last)
   );
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt    = state;
      load   = 1'b0;
      clr    = 1'b0;
      inc    = 1'b0;
      done_d = 1'b0;
      case (state)
         IDLE:  if (Start) begin
                   nxt = READ;
                   clr = 1'b1;
                end
         READ:  begin
                   nxt  = VALID;
                   load = 1'b1;
                end
         VALID: if (win_ready) begin
                   clr    = last;
                   inc    = ~last;
                   done_d = last;
`ifdef FC1_READER_PREFETCH_EN
                   nxt    = last ? IDLE : VALID;
                   load   = ~last;
`else
                   nxt    = last ? IDLE : READ;
`endif
                end
         default: nxt = IDLE;
      endcase
   end
`ifdef FC1_READER_PREFETCH_EN
   assign Read_Enable = (state == READ) | ((state == VALID) & win_ready & ~last);
   assign Read_Width  = (state == READ) ? base : (Read_Enable ? next_base : '0);
`else
   logic re_q;
   logic [ADDR_W-1:0] rw_q;
   // strobe and address are staged one cycle ahead so they are clean register outputs in READ
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         re_q <= 1'b0;
         rw_q <= '0;
      end else begin
         re_q <= (nxt == READ);
         rw_q <= (nxt == READ) ? ((state == VALID) ? next_base : base) : '0;
      end
   assign Read_Enable = re_q;
   assign Read_Width  = rw_q;
`endif
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         Done       <= 1'b0;
         win_data_0 <= '0;
         win_data_1 <= '0;
         win_data_2 <= '0;
         win_data_3 <= '0;
         win_data_4 <= '0;
      end else begin
         Done <= done_d;
         if (load) begin
            win_data_0 <= ram_data_0;
            win_data_1 <= ram_data_1;
            win_data_2 <= ram_data_2;
            win_data_3 <= ram_data_3;
            win_data_4 <= ram_data_4;
         end
      end
   assign Busy      = (state != IDLE);
   assign win_valid = (state == VALID);
   assign win_index = index;
   assign win_last  = win_valid & last;
endmodule

// File: tb/tb_fc_1st_window_reader.sv
// tb_fc_1st_window_reader: randomized self-checking bench against a window-list reference model
module tb_fc_1st_window_reader;
   localparam int BW = 16, DEPTH = 32, NW = (DEPTH + 4) / 5;
`ifdef FC1_READER_PREFETCH_EN
   localparam int PF = 1;
`else
   localparam int PF = 0;
`endif
   logic CLK = 1'b0, RST_N = 1'b1, Start = 1'b0, win_ready = 1'b0;
   logic Busy, Done, Read_Enable, win_valid, win_last;
   logic [4:0] Read_Width;
   logic [2:0] win_index;
   logic signed [BW-1:0] lane [5];
   logic signed [BW-1:0] wd [5];
   logic signed [BW-1:0] mem [DEPTH];
   int tests = 0, fails = 0;

   fc_1st_window_reader dut (
      .CLK(CLK), .RST_N(RST_N), .Start(Start), .Busy(Busy), .Done(Done),
      .Read_Enable(Read_Enable), .Read_Width(Read_Width),
      .ram_data_0(lane[0]), .ram_data_1(lane[1]), .ram_data_2(lane[2]),
      .ram_data_3(lane[3]), .ram_data_4(lane[4]),
      .win_data_0(wd[0]), .win_data_1(wd[1]), .win_data_2(wd[2]),
      .win_data_3(wd[3]), .win_data_4(wd[4]),
      .win_valid(win_valid), .win_ready(win_ready),
      .win_index(win_index), .win_last(win_last)
   );

   always #5 CLK = ~CLK;

   // RAM: samples the strobe on negedge, zero-pads past the last entry
   always @(negedge CLK)
      if (Read_Enable)
         for (int j = 0; j < 5; j++)
            lane[j] = (int'(Read_Width) + j < DEPTH) ? mem[int'(Read_Width) + j] : '0;

   task automatic chk(input string tag, input logic signed [31:0] o, input logic signed [31:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, o, e);
      end
   endtask

   function automatic logic signed [31:0] exp_lane(input int k, input int j);
      int a;
      a = 5 * k + j;
      return (a < DEPTH) ? mem[a] : 0;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, Busy, 0);
      chk({tag, "_done"}, Done, 0);
      chk({tag, "_re"}, Read_Enable, 0);
      chk({tag, "_rw"}, Read_Width, 0);
      chk({tag, "_valid"}, win_valid, 0);
      chk({tag, "_index"}, win_index, 0);
      chk({tag, "_last"}, win_last, 0);
      for (int j = 0; j < 5; j++) chk({tag, "_data"}, wd[j], 0);
   endtask

   // mode 0: ready always high; 1: stall 5 cycles on window 2 plus a stray Start; 2: random ready/Start
   task automatic run_pass(input int mode, input int abort_win);
      int k, cyc, first_hs, last_hs, first_v, stall, dones;
      logic r;
      k = 0; cyc = 0; first_hs = -1; last_hs = -1; first_v = -1; stall = 0; dones = 0;
      Start = 1'b1;
      win_ready = 1'b0;
      step();
      Start = 1'b0;
      chk("busy_after_start", Busy, 1);
      chk("done_cleared", Done, 0);
      while (k < NW && cyc < 400) begin
         Start = 1'b0;
         if (Done) dones++;
         if (win_valid) begin
            if (first_v < 0) first_v = cyc + 1;
            for (int j = 0; j < 5; j++) chk("lane", wd[j], exp_lane(k, j));
            chk("win_index", win_index, k);
            chk("win_last", win_last, k == NW - 1);
         end else begin
            chk("busy_in_read", Busy, 1);
            chk("read_en_read", Read_Enable, 1);
            chk("read_width_read", Read_Width, 5 * k);
         end
         if (win_valid && k == abort_win) begin
            RST_N = 1'b0;
            #1;
            chk_zero("abort");
            repeat (3) begin
               step();
               chk("no_done_in_reset", Done, 0);
            end
            RST_N = 1'b1;
            step();
            chk("idle_after_abort", Busy, 0);
            chk("no_done_after_abort", Done, 0);
            return;
         end
         r = (mode == 0) ? 1'b1 : (mode == 1) ? !(k == 2 && stall < 5) : 1'($urandom_range(0, 1));
         if (mode == 1 && k == 2 && win_valid && !r) stall++;
         if ((mode == 1 && cyc == 3) || (mode == 2 && $urandom_range(0, 5) == 0)) Start = 1'b1;
         win_ready = r;
         #1;
         if (win_valid) begin
            chk("read_en_valid", Read_Enable, PF != 0 && r && k < NW - 1);
            if (Read_Enable) chk("prefetch_addr", Read_Width, 5 * (k + 1));
         end
         if (win_valid && r) begin
            if (first_hs < 0) first_hs = cyc + 1;
            last_hs = cyc + 1;
            k++;
         end
         step();
         cyc++;
      end
      Start = 1'b0;
      chk("windows_seen", k, NW);
      chk("done_early", dones, 0);
      chk("done_pulse", Done, 1);
      chk("busy_end", Busy, 0);
      chk("valid_end", win_valid, 0);
      if (mode != 2) begin
         chk("first_valid_latency", first_v, 2);
         chk("first_handshake", first_hs, 2);
      end
      if (mode == 0) chk("last_handshake", last_hs, 2 + (NW - 1) * (PF != 0 ? 1 : 2));
   endtask

   initial begin
      for (int j = 0; j < 5; j++) lane[j] = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = BW'(i + 1);
      #2 RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk_zero("reset");
      RST_N = 1'b1;
      step();
      chk("idle_busy", Busy, 0);
      run_pass(0, -1);
      run_pass(1, -1);
      run_pass(0, 3);
      run_pass(0, -1);
      for (int i = 0; i < 5; i++) mem[i] = -16'sd1;
      run_pass(0, -1);
      for (int i = 0; i < DEPTH; i++) mem[i] = BW'($urandom);
      repeat (3) run_pass(2, -1);
      step();
      chk("final_done_low", Done, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
